// File: rtl/config_status_tx_pkg.sv
// ---------------------------------------------------------------------------
// config_status_tx_pkg
// Shared definitions for the configuration register path. Both the config
// receive block and the status readback transmitter use these so that the
// byte format (index in [7:4], data in [3:0]) stays identical on both sides.
//
// Contents:
//   CFG_IDX_*   - register index carried in the upper nibble of a config byte
//   SEL_*       - readback request selector encodings (req_sel)
//   tx_state_t  - readback transmitter FSM states
//   make_cfg_byte() - packs an index/data pair into one config byte
// ---------------------------------------------------------------------------
package config_status_tx_pkg;

    localparam logic [3:0] CFG_IDX_MODE       = 4'd0;
    localparam logic [3:0] CFG_IDX_BRIGHTNESS = 4'd1;
    localparam logic [3:0] CFG_IDX_ANIM       = 4'd2;

    localparam logic [1:0] SEL_MODE       = 2'd0;
    localparam logic [1:0] SEL_BRIGHTNESS = 2'd1;
    localparam logic [1:0] SEL_ANIM       = 2'd2;
    localparam logic [1:0] SEL_DUMP       = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        NEXT = 2'd3
    } tx_state_t;

    function automatic logic [7:0] make_cfg_byte(input logic [3:0] idx,
                                                 input logic [3:0] data);
        return {idx, data};
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
// 8N1 UART transmitter: start bit (0), 8 data bits LSB first, stop bit (1),
// every bit held for exactly CLKS_PER_BIT clocks.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, aborts any frame in flight
//   start - one-cycle strobe, latches data and begins a frame
//   data  - byte to send, sampled when start is high
//   tx    - registered serial line, idle high
//   done  - high for one cycle during the final clock of the stop bit
//
// The line output is registered one stage behind the internal frame state,
// so tx reaches the pin one clock after the shift register moves. done is
// raised on the internal timeline, which is one clock ahead of tx; this lets
// the controlling FSM queue the next byte so the line only idles two clocks
// between frames.
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     BIT_LAST = 4'd9;

    logic          active;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_cnt;
    logic [9:0]    frame;
    logic          bit_end;

    assign bit_end = active && (cnt == CNT_LAST);
    assign done    = bit_end && (bit_cnt == BIT_LAST);

    // Frame shifter: the whole 10-bit frame is loaded at once and shifted
    // right at the end of each bit period, filling with ones so the line
    // naturally rests high. The bit-period counter wraps straight back to
    // zero on the last count so no bit is ever stretched.
    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            cnt     <= '0;
            bit_cnt <= '0;
            frame   <= '1;
            tx      <= 1'b1;
        end else begin
            tx <= active ? frame[0] : 1'b1;
            if (start) begin
                frame   <= {1'b1, data, 1'b0};
                active  <= 1'b1;
                cnt     <= '0;
                bit_cnt <= '0;
            end else if (active) begin
                if (bit_end) begin
                    cnt   <= '0;
                    frame <= {1'b1, frame[9:1]};
                    if (bit_cnt == BIT_LAST) begin
                        active <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/config_status_tx.sv
// ---------------------------------------------------------------------------
// config_status_tx
// Configuration readback: on request, sends the current mode, brightness
// and/or animation select over UART in the same index/data byte format the
// config receive path decodes.
//
// Ports:
//   clk           - clock, rising edge
//   rst           - synchronous active-high reset
//   mode          - current mode register (4 bits)
//   brightness    - current brightness register (4 bits)
//   animation_sel - current animation select (4 bits)
//   req_valid     - readback request strobe
//   req_sel       - 0 mode, 1 brightness, 2 animation_sel, 3 dump all three
//   req_ready     - high in IDLE only; request taken when valid & ready
//   tx            - UART serial line, idle high
//   busy          - high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module config_status_tx
    import config_status_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] mode,
    input  logic [3:0] brightness,
    input  logic [3:0] animation_sel,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    output logic       req_ready,
    output logic       tx,
    output logic       busy
);

    tx_state_t  state;
    tx_state_t  next_state;
    logic [3:0] snap_mode;
    logic [3:0] snap_brightness;
    logic [3:0] snap_anim;
    logic [1:0] byte_idx;
    logic [1:0] last_idx;
    logic       accept;
    logic       ser_start;
    logic       ser_done;
    logic [7:0] ser_data;

    assign accept = (state == IDLE) && req_valid;

    // State register; reset wins over a request arriving on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request snapshot and byte sequencing. All three values are captured on
    // acceptance so a dump is self-consistent even if the registers change
    // while it is going out. byte_idx reuses the req_sel encoding, and a
    // single read is just a dump whose first and last index coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_mode       <= '0;
            snap_brightness <= '0;
            snap_anim       <= '0;
            byte_idx        <= '0;
            last_idx        <= '0;
        end else if (accept) begin
            snap_mode       <= mode;
            snap_brightness <= brightness;
            snap_anim       <= animation_sel;
            byte_idx        <= (req_sel == SEL_DUMP) ? SEL_MODE : req_sel;
            last_idx        <= (req_sel == SEL_DUMP) ? SEL_ANIM : req_sel;
        end else if ((state == NEXT) && (byte_idx != last_idx)) begin
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // Next-state and output decode. LOAD lasts one cycle and is the only
    // cycle the serializer is told to start; NEXT decides between another
    // byte and going idle.
    always_comb begin
        next_state = state;
        ser_start  = 1'b0;
        req_ready  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                ser_start  = 1'b1;
                next_state = SEND;
            end
            SEND: begin
                if (ser_done) begin
                    next_state = NEXT;
                end
            end
            NEXT: begin
                next_state = (byte_idx != last_idx) ? LOAD : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Byte to transmit for the current index, built from the snapshot.
    always_comb begin
        ser_data = make_cfg_byte(CFG_IDX_MODE, snap_mode);
        case (byte_idx)
            SEL_BRIGHTNESS: ser_data = make_cfg_byte(CFG_IDX_BRIGHTNESS, snap_brightness);
            SEL_ANIM:       ser_data = make_cfg_byte(CFG_IDX_ANIM, snap_anim);
            default:        ser_data = make_cfg_byte(CFG_IDX_MODE, snap_mode);
        endcase
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serializer (
        .clk   (clk),
        .rst   (rst),
        .start (ser_start),
        .data  (ser_data),
        .tx    (tx),
        .done  (ser_done)
    );

endmodule

// File: tb/tb_config_status_tx.sv
// ---------------------------------------------------------------------------
// tb_config_status_tx
// Directed bench for config_status_tx with CLKS_PER_BIT = 4. Expected bytes
// are queued when a request is accepted and popped as each UART frame is
// captured from tx.
// ---------------------------------------------------------------------------
module tb_config_status_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam int WAIT_LIMIT = 200;

    logic       clk;
    logic       rst;
    logic [3:0] mode;
    logic [3:0] brightness;
    logic [3:0] animation_sel;
    logic       req_valid;
    logic [1:0] req_sel;
    logic       req_ready;
    logic       tx;
    logic       busy;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic       ready_during_busy;

    config_status_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mode          (mode),
        .brightness    (brightness),
        .animation_sel (animation_sel),
        .req_valid     (req_valid),
        .req_sel       (req_sel),
        .req_ready     (req_ready),
        .tx            (tx),
        .busy          (busy)
    );

    // Free-running 100 MHz-style clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Raise a request, wait (bounded) for req_ready, and return just after
    // the acceptance edge with the expected bytes queued.
    task automatic applyStimulus(input logic [1:0] sel);
        int waited;
        @(negedge clk);
        req_sel   = sel;
        req_valid = 1'b1;
        waited    = 0;
        while (req_ready !== 1'b1 && waited < WAIT_LIMIT) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("accept_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (sel == 2'd3) begin
            exp_q.push_back({4'd0, mode});
            exp_q.push_back({4'd1, brightness});
            exp_q.push_back({4'd2, animation_sel});
        end else if (sel == 2'd0) begin
            exp_q.push_back({4'd0, mode});
        end else if (sel == 2'd1) begin
            exp_q.push_back({4'd1, brightness});
        end else begin
            exp_q.push_back({4'd2, animation_sel});
        end
    endtask

    // Capture one frame starting at the next negedge. The number of high
    // samples before the start bit must be 2, both after an acceptance edge
    // and between bytes of a dump. Every sample of the frame is compared to
    // the ideal 8N1 waveform of the expected byte.
    task automatic checkFrame(input string tag);
        logic [7:0] exp_byte;
        logic [7:0] got;
        logic [9:0] bits;
        logic       samples[FRAME];
        logic       busy_last;
        int         lat;
        int         bad;
        checkOutput($sformatf("%s_queued", tag), {31'd0, exp_q.size() > 0}, 32'd1);
        exp_byte = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        lat = 0;
        @(negedge clk);
        while (tx !== 1'b0 && lat < WAIT_LIMIT) begin
            lat++;
            @(negedge clk);
        end
        checkOutput($sformatf("%s_start_gap", tag), lat, 2);
        if (lat >= WAIT_LIMIT) begin
            return;
        end
        busy_last = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) begin
                @(negedge clk);
            end
            samples[i] = tx;
            busy_last  = busy;
        end
        bits = {1'b1, exp_byte, 1'b0};
        bad  = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (samples[i] !== bits[i / CPB]) begin
                bad++;
            end
        end
        for (int k = 0; k < 8; k++) begin
            got[k] = samples[(k + 1) * CPB + CPB / 2];
        end
        checkOutput($sformatf("%s_byte", tag), {24'd0, got}, {24'd0, exp_byte});
        checkOutput($sformatf("%s_waveform_errs", tag), bad, 0);
        checkOutput($sformatf("%s_busy_in_stop", tag), {31'd0, busy_last}, 32'd1);
    endtask

    // One cycle after the final stop bit: idle line, ready, not busy.
    task automatic checkIdle(input string tag);
        @(negedge clk);
        checkOutput($sformatf("%s_busy", tag), {31'd0, busy}, 32'd0);
        checkOutput($sformatf("%s_ready", tag), {31'd0, req_ready}, 32'd1);
        checkOutput($sformatf("%s_tx", tag), {31'd0, tx}, 32'd1);
    endtask

    // Watch the line for a while and count any low samples.
    task automatic checkQuiet(input string tag, input int cycles);
        int lows;
        int busies;
        lows   = 0;
        busies = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) busies++;
        end
        checkOutput($sformatf("%s_tx_lows", tag), lows, 0);
        checkOutput($sformatf("%s_busy_cycles", tag), busies, 0);
    endtask

    initial begin
        int         lat;
        logic [7:0] abort_byte;

        rst           = 1'b1;
        req_valid     = 1'b0;
        req_sel       = 2'd0;
        mode          = 4'd0;
        brightness    = 4'd0;
        animation_sel = 4'd0;
        ready_during_busy = 1'bx;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("reset_tx", {31'd0, tx}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_ready", {31'd0, req_ready}, 32'd1);

        // Single read of mode
        mode = 4'h5;
        applyStimulus(2'd0);
        checkFrame("single");
        checkIdle("single_idle");

        // Dump of all three registers
        mode          = 4'h2;
        brightness    = 4'hF;
        animation_sel = 4'h1;
        applyStimulus(2'd3);
        checkFrame("dump0");
        checkFrame("dump1");
        checkFrame("dump2");
        checkIdle("dump_idle");

        // Snapshot: brightness changes while its byte is on the line
        brightness = 4'h9;
        applyStimulus(2'd1);
        fork
            begin
                repeat (12) @(negedge clk);
                brightness = 4'h3;
            end
        join_none
        checkFrame("snapshot");
        checkIdle("snapshot_idle");
        applyStimulus(2'd1);
        checkFrame("snapshot_new");
        checkIdle("snapshot_new_idle");

        // Request held during a transfer, then taken on the first IDLE edge
        mode          = 4'h7;
        animation_sel = 4'hA;
        applyStimulus(2'd0);
        req_sel   = 2'd2;
        req_valid = 1'b1;
        fork
            begin
                repeat (10) @(negedge clk);
                ready_during_busy = req_ready;
            end
        join_none
        checkFrame("held_first");
        checkOutput("held_ready_while_busy", {31'd0, ready_during_busy}, 32'd0);
        @(negedge clk);
        checkOutput("b2b_ready_on_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        exp_q.push_back({4'd2, animation_sel});
        checkFrame("b2b");
        checkIdle("b2b_idle");
        checkQuiet("held_no_extra", 60);

        // Reset during data bit 3, with a request on the same edge
        mode       = 4'hA;
        abort_byte = {4'd0, mode};
        applyStimulus(2'd0);
        lat = 0;
        @(negedge clk);
        while (tx !== 1'b0 && lat < WAIT_LIMIT) begin
            lat++;
            @(negedge clk);
        end
        checkOutput("abort_start_gap", lat, 2);
        repeat (4 * CPB + 1) @(negedge clk);
        checkOutput("abort_pre_bit3", {31'd0, tx}, {31'd0, abort_byte[3]});
        rst       = 1'b1;
        req_valid = 1'b1;
        req_sel   = 2'd3;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("abort_tx", {31'd0, tx}, 32'd1);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_ready", {31'd0, req_ready}, 32'd1);
        checkQuiet("abort_quiet", 60);

        // Normal operation after the abort
        animation_sel = 4'hC;
        applyStimulus(2'd2);
        checkFrame("recover");
        checkIdle("recover_idle");

        checkOutput("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
